spi_slave: RTL
==============

# spi_slave

SPI mode-0 responder that forms the far end of the team's `spi_master` link. It lets a second board, or a loopback on the same board, answer master transactions. The block oversamples `sclk`, `cs_n` and `mosi` in the `clk` domain, assembles MSB-first words into `rx_data`, and shifts a preloaded word out on `miso`. It sits between the SPI pins and user logic such as switches, LEDs or the 7-segment driver.

## Interface
- `WIDTH`, 16, frame length in bits; must be ≥ 2.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sclk` in 1: SPI clock from the master; asynchronous to `clk`.
- `cs_n` in 1: chip select, active low; asynchronous.
- `mosi` in 1: master-out data; asynchronous.
- `miso` out 1: slave-out data; `0` while not selected.
- `tx_data` in WIDTH: word to transmit.
- `tx_load` in 1: one-cycle strobe that writes `tx_data` into the holding register.
- `tx_pending` out 1: holding register written since the last word start.
- `rx_data` out WIDTH: last complete received word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high while selected (state ACTIVE).
- `frame_err` out 1: sticky framing error; present only with `SPI_SLAVE_ERR_EN`.

## Operation
- **Synchronisers and edge detection:**
  - 2-flop synchronisers on `sclk`, `cs_n` and `mosi`.
  - One further register on the synchronised `sclk` and `cs_n` for edge detection.
  - Synchroniser reset values: `sclk` = 0, `cs_n` = 1, `mosi` = 0.
- **Registers:**
  - `hold` (WIDTH): transmit holding register.
  - `tx_sh` (WIDTH): transmit shift register.
  - `rx_sh` (WIDTH): receive shift register.
  - `bit_cnt` (log2(WIDTH)+1 bits).
- **IDLE:**
  - `miso` = 0, `busy` = 0.
  - On a synchronised `cs_n` fall: `tx_sh` ← `hold`, `bit_cnt` ← 0, `tx_pending` ← 0, go to ACTIVE.
- **ACTIVE:** `miso` = `tx_sh[WIDTH-1]`.
  - **Synchronised `sclk` rise:**
    - `rx_sh` ← {`rx_sh[WIDTH-2:0]`, synchronised `mosi`}; `bit_cnt` increments.
    - When `bit_cnt` reaches WIDTH: `rx_data` ← completed word, `rx_valid` pulses, `bit_cnt` ← 0, `tx_sh` ← `hold`, `tx_pending` ← 0.
    - This gives back-to-back words within one `cs_n` low period.
  - **Synchronised `sclk` fall:** `tx_sh` shifts left by one, filling with 0, only if `bit_cnt` ≠ 0. The fall that follows a word boundary is therefore suppressed.
  - **Synchronised `cs_n` rise:** go to IDLE and discard the partial word in `rx_sh`. No `rx_valid` is produced.
- **`tx_load`:**
  - Accepted in any state: `hold` ← `tx_data`, `tx_pending` ← 1.
  - If `tx_load` coincides with a word start (either the `cs_n` fall or a reload), the new `tx_data` goes directly into `tx_sh`.
  - In that case `tx_pending` ends at 0.
- **Unloaded `hold`:** if `hold` is not reloaded, the same word is retransmitted.
- **Simultaneous synchronised events:**
  - A `cs_n` rise together with an `sclk` edge: the `cs_n` rise wins and the edge is ignored.
  - A `cs_n` fall together with an `sclk` edge cannot be legal in mode 0; it is treated as the `cs_n` fall only.
- **Reset:**
  - Reset mid-frame returns immediately to IDLE.
  - Reset values: `miso` 0, `rx_data` 0, `rx_valid` 0, `busy` 0, `tx_pending` 0, `frame_err` 0, `hold` 0, `tx_sh` 0, `rx_sh` 0, `bit_cnt` 0.

## Timing
- **Clock ratio:** `clk` frequency ≥ 8× `sclk` frequency. Each `sclk` phase must last ≥ 4 `clk` periods.
- **Edge detection:** a pin edge on `sclk` or `cs_n` is detected 3 `clk` rising edges after it stable-crosses the synchroniser.
- **`rx_valid`:** asserted on the 4th `clk` edge after the pin `sclk` rise of bit WIDTH-1, for exactly one cycle.
- **`miso` after select:** valid with the first bit 4 `clk` edges after the pin `cs_n` fall. The master must wait ≥ 5 `clk` before its first `sclk` rise.
- **`miso` after a falling `sclk`:** changes 4 `clk` edges after the pin fall. This is before the next master sample when the clock ratio holds.
- **Deselect:** `busy` and `miso` clear 4 `clk` edges after the pin `cs_n` rise.

## Configuration
- **`SPI_SLAVE_ERR_EN` defined:**
  - `frame_err` port exists.
  - It sets when a synchronised `cs_n` rise occurs with `bit_cnt` ≠ 0.
  - It clears only on `reset` or on a `tx_load` strobe.
- **`SPI_SLAVE_ERR_EN` not defined:** the port and its logic are absent. Truncated frames are discarded silently.

## Test plan
- **Basic exchange:** `tx_load` with `tx_data` = 16'hA55A, then a 16-bit master frame with `mosi` = 16'h1234 at 8:1 ratio.
  - `rx_data` = 16'h1234 with one `rx_valid` pulse.
  - Master captures 16'hA55A.
  - `tx_pending` = 0 after select.
- **Back-to-back words:** 32 `sclk` clocks in one `cs_n` low, `mosi` words 16'hBEEF then 16'h0001; `tx_load` 16'hC0DE during the first word.
  - Two `rx_valid` pulses, carrying 16'hBEEF and 16'h0001.
  - `miso` words are the prior `hold` value, then 16'hC0DE.
- **Truncated frame:** `cs_n` raised after 9 bits.
  - No `rx_valid`; `rx_data` is unchanged.
  - `frame_err` = 1 with `SPI_SLAVE_ERR_EN`.
  - The next full frame is received correctly.
- **Retransmit:** two frames with no `tx_load` in between. Both frames transmit the same `hold` word.
- **Reset mid-frame:** `reset` pulsed after 5 bits.
  - All outputs go to 0, `busy` = 0.
  - A following frame with `mosi` = 16'hFFFF gives `rx_data` = 16'hFFFF.
- **Load at select:** `tx_load` with 16'h8001 in the same cycle as the synchronised `cs_n` fall.
  - Master receives 16'h8001.
  - `tx_pending` = 0.

Source files
------------

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI mode-0 responder. sclk, cs_n and mosi are oversampled in the clk
//   domain through 2-flop synchronisers. MSB-first words are assembled into
//   o_rx_data, and a preloaded word is shifted out on o_miso. Several words
//   may be exchanged back-to-back within one cs_n low period.
//
//   Optional feature: define SPI_SLAVE_ERR_EN to add the sticky o_frame_err
//   output. It flags a deselect that arrives in the middle of a word.
//
// Ports
//   i_clk        system clock; all logic runs on its rising edge
//   i_reset      asynchronous, active-high reset
//   i_sclk       SPI clock from the master (asynchronous)
//   i_cs_n       chip select, active low (asynchronous)
//   i_mosi       master-out data (asynchronous)
//   o_miso       slave-out data, 0 while not selected
//   i_tx_data    word to transmit
//   i_tx_load    one-cycle strobe that writes i_tx_data into the holding reg
//   o_tx_pending holding register written since the last word start
//   o_rx_data    last complete received word
//   o_rx_valid   one-cycle pulse when o_rx_data updates
//   o_busy       high while selected
//   o_frame_err  sticky truncated-frame flag (SPI_SLAVE_ERR_EN only)
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_load,
    output logic             o_tx_pending,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_busy
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic             o_frame_err
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_cs_meta, r_cs_sync, r_cs_prev;
    logic r_mosi_meta, r_mosi_sync;

    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_tx_sh;
    logic [WIDTH-1:0] r_rx_sh;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_tx_pending;
    logic             r_word_done;

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic w_word_start, w_word_done, w_shift_in, w_shift_out, w_abort;
    logic [WIDTH-1:0] w_rx_next;

    // Pin synchronisers plus one extra stage on sclk/cs_n for edge detection.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_cs_meta   <= i_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_cs_fall   = ~r_cs_sync & r_cs_prev;
    assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
    assign w_rx_next   = {r_rx_sh[WIDTH-2:0], r_mosi_sync};

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes. In ACTIVE a cs_n rise beats any
    // simultaneous sclk edge; a cs_n fall is only seen in IDLE, where sclk
    // edges are ignored.
    always_comb begin
        w_state_next = r_state;
        w_word_start = 1'b0;
        w_word_done  = 1'b0;
        w_shift_in   = 1'b0;
        w_shift_out  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_word_start = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else if (w_sclk_rise) begin
                    w_shift_in = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_word_done  = 1'b1;
                        w_word_start = 1'b1;
                    end else begin
                        w_word_done  = 1'b0;
                    end
                end else if (w_sclk_fall && (r_bit_cnt != {CW{1'b0}})) begin
                    // The fall right after a word boundary is skipped so the
                    // freshly loaded MSB stays on miso for the next rise.
                    w_shift_out = 1'b1;
                end else begin
                    w_shift_out = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift registers, bit counter, holding register and pending flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold       <= {WIDTH{1'b0}};
            r_tx_sh      <= {WIDTH{1'b0}};
            r_rx_sh      <= {WIDTH{1'b0}};
            r_bit_cnt    <= {CW{1'b0}};
            r_tx_pending <= 1'b0;
            r_word_done  <= 1'b0;
        end else begin
            if (i_tx_load) begin
                r_hold <= i_tx_data;
            end
            // A load coinciding with a word start bypasses the holding reg.
            if (w_word_start) begin
                r_tx_sh <= i_tx_load ? i_tx_data : r_hold;
            end else if (w_shift_out) begin
                r_tx_sh <= {r_tx_sh[WIDTH-2:0], 1'b0};
            end
            if (w_word_start) begin
                r_tx_pending <= 1'b0;
            end else if (i_tx_load) begin
                r_tx_pending <= 1'b1;
            end
            if (w_abort) begin
                r_rx_sh <= {WIDTH{1'b0}};
            end else if (w_shift_in) begin
                r_rx_sh <= w_rx_next;
            end
            if (w_word_start) begin
                r_bit_cnt <= {CW{1'b0}};
            end else if (w_shift_in) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            r_word_done <= w_word_done;
        end
    end

    // Registered outputs; they trail the internal state by one clk.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_miso     <= 1'b0;
            o_busy     <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_data  <= {WIDTH{1'b0}};
        end else begin
            o_miso     <= (r_state == ST_ACTIVE) & r_tx_sh[WIDTH-1];
            o_busy     <= (r_state == ST_ACTIVE);
            o_rx_valid <= r_word_done;
            if (r_word_done) begin
                o_rx_data <= r_rx_sh;
            end
        end
    end

    assign o_tx_pending = r_tx_pending;

`ifdef SPI_SLAVE_ERR_EN
    // Sticky truncated-frame flag; a new error takes priority over the clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_frame_err <= 1'b0;
        end else if (w_abort && (r_bit_cnt != {CW{1'b0}})) begin
            o_frame_err <= 1'b1;
        end else if (i_tx_load) begin
            o_frame_err <= 1'b0;
        end
    end
`endif

endmodule
